// File: rtl/tw_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : tw_slave_sync
// Purpose  : Three-wire (clock / chip-select / data) serial slave. The bus
//            pins are brought into the in_clk domain through 2-flop
//            synchronizers. Frames are decoded into local register-bus
//            write strobes and read requests. Read data is shifted back to
//            the master through a pad output enable.
// Frame    : CS low, mode bit (1=write, 0=read), address, data; MSB first.
//            The master changes data after tw_clock falls. The slave samples
//            on rising edges and drives read data on falling edges.
// Ports    : in_clk / in_reset_n    - system clock, synchronous active-low reset
//            in_tw_clock, in_tw_cs_n, in_tw_data - asynchronous bus inputs
//            out_tw_data, out_tw_data_oe        - bus data out and pad enable
//            out_reg_addr, out_reg_wr_en, out_reg_wr_data - register write port
//            out_reg_rd_en, in_reg_rd_data - register read port; data is
//                                            returned 1 cycle after rd_en
//            out_abort - one-cycle pulse when a frame is cut short by CS
// Revision : 1.0 - initial release
// ============================================================================
module tw_slave_sync #(
    parameter int TWS_ADDRESS_BITS = 16,
    parameter int TWS_DATA_BITS    = 32
) (
    input  logic                        in_clk,
    input  logic                        in_reset_n,
    input  logic                        in_tw_clock,
    input  logic                        in_tw_cs_n,
    input  logic                        in_tw_data,
    output logic                        out_tw_data,
    output logic                        out_tw_data_oe,
    output logic [TWS_ADDRESS_BITS-1:0] out_reg_addr,
    output logic                        out_reg_wr_en,
    output logic [TWS_DATA_BITS-1:0]    out_reg_wr_data,
    output logic                        out_reg_rd_en,
    input  logic [TWS_DATA_BITS-1:0]    in_reg_rd_data,
    output logic                        out_abort
);

    localparam int c_cnt_max = (TWS_ADDRESS_BITS > TWS_DATA_BITS) ? TWS_ADDRESS_BITS : TWS_DATA_BITS;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_addr_last = c_cnt_w'(TWS_ADDRESS_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(TWS_DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_data_bits = c_cnt_w'(TWS_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MODE    = 3'd1,
        ADDR    = 3'd2,
        WDATA   = 3'd3,
        TURN    = 3'd4,
        RDATA   = 3'd5,
        WAIT_CS = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge-detect history
    // ------------------------------------------------------------------
    logic tw_clk_s1_q, tw_clk_s2_q, tw_clk_prev_q;
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic dat_s1_q, dat_s2_q;

    logic w_tw_rise, w_tw_fall, w_cs_rise, w_cs_fall, w_in_frame;

    assign w_tw_rise = tw_clk_s2_q & ~tw_clk_prev_q;
    assign w_tw_fall = ~tw_clk_s2_q & tw_clk_prev_q;
    assign w_cs_rise = cs_s2_q & ~cs_prev_q;
    assign w_cs_fall = ~cs_s2_q & cs_prev_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                      state_q, state_d;
    logic [c_cnt_w-1:0]          bit_cnt_q, bit_cnt_d;
    logic                        mode_q, mode_d;
    logic [TWS_ADDRESS_BITS-1:0] addr_sh_q, addr_sh_d;
    logic [TWS_DATA_BITS-1:0]    wdata_sh_q, wdata_sh_d;
    logic [TWS_DATA_BITS-1:0]    tx_sh_q, tx_sh_d;
    logic                        turn_seen_q, turn_seen_d;
    logic                        load_tx_q, load_tx_d;
    logic [TWS_ADDRESS_BITS-1:0] reg_addr_q, reg_addr_d;
    logic [TWS_DATA_BITS-1:0]    wr_data_q, wr_data_d;
    logic                        wr_en_q, wr_en_d;
    logic                        rd_en_q, rd_en_d;
    logic                        abort_q, abort_d;
    logic                        tw_data_q, tw_data_d;
    logic                        oe_q, oe_d;
    // The CS synchronizer resets to "high", so leaving reset while the master
    // already holds CS low looks like a falling edge. armed_q only opens the
    // IDLE->MODE path once CS has really been seen high with the
    // synchronizer flushed (settle_q saturated). That drops the rest of a
    // frame that reset interrupted.
    logic [1:0]                  settle_q, settle_d;
    logic                        armed_q, armed_d;

    assign w_in_frame = (state_q == MODE) || (state_q == ADDR) || (state_q == WDATA) ||
                        (state_q == TURN) || (state_q == RDATA);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        mode_d      = mode_q;
        addr_sh_d   = addr_sh_q;
        wdata_sh_d  = wdata_sh_q;
        tx_sh_d     = tx_sh_q;
        turn_seen_d = turn_seen_q;
        load_tx_d   = rd_en_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        abort_d     = 1'b0;
        tw_data_d   = tw_data_q;
        oe_d        = oe_q;
        settle_d    = settle_q;
        armed_d     = armed_q;

        if (settle_q != 2'd3) begin
            settle_d = settle_q + 2'd1;
        end
        if ((settle_q == 2'd3) && cs_s2_q && cs_prev_q) begin
            armed_d = 1'b1;
        end

        // Read data arrives one cycle after the rd_en pulse has been seen.
        if (load_tx_q) begin
            tx_sh_d = in_reg_rd_data;
        end

        if (w_in_frame && w_cs_rise) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            tw_data_d = 1'b0;
            abort_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d = 1'b0;
                    if (w_cs_fall && armed_q) begin
                        state_d   = MODE;
                        bit_cnt_d = '0;
                    end
                end
                MODE: begin
                    if (w_tw_rise) begin
                        mode_d    = dat_s2_q;
                        bit_cnt_d = '0;
                        state_d   = ADDR;
                    end
                end
                ADDR: begin
                    if (w_tw_rise) begin
                        addr_sh_d = {addr_sh_q[TWS_ADDRESS_BITS-2:0], dat_s2_q};
                        bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
                        if (bit_cnt_q == c_addr_last) begin
                            reg_addr_d = addr_sh_d;
                            bit_cnt_d  = '0;
                            if (mode_q) begin
                                state_d = WDATA;
                            end else begin
                                state_d     = TURN;
                                rd_en_d     = 1'b1;
                                turn_seen_d = 1'b0;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (w_tw_rise) begin
                        wdata_sh_d = {wdata_sh_q[TWS_DATA_BITS-2:0], dat_s2_q};
                        bit_cnt_d  = bit_cnt_q + c_cnt_w'(1);
                        if (bit_cnt_q == c_data_last) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = wdata_sh_d;
                            state_d   = WAIT_CS;
                        end
                    end
                end
                TURN: begin
                    // The fall that follows the last address bit is ignored;
                    // one full turnaround clock passes before we drive.
                    if (w_tw_rise) begin
                        turn_seen_d = 1'b1;
                    end else if (w_tw_fall && turn_seen_q) begin
                        oe_d      = 1'b1;
                        tw_data_d = tx_sh_q[TWS_DATA_BITS-1];
                        tx_sh_d   = {tx_sh_q[TWS_DATA_BITS-2:0], 1'b0};
                        bit_cnt_d = c_cnt_w'(1);
                        state_d   = RDATA;
                    end
                end
                RDATA: begin
                    if (w_tw_fall) begin
                        if (bit_cnt_q == c_data_bits) begin
                            oe_d      = 1'b0;
                            tw_data_d = 1'b0;
                            state_d   = WAIT_CS;
                        end else begin
                            tw_data_d = tx_sh_q[TWS_DATA_BITS-1];
                            tx_sh_d   = {tx_sh_q[TWS_DATA_BITS-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
                        end
                    end
                end
                WAIT_CS: begin
                    oe_d = 1'b0;
                    if (w_cs_rise) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            tw_clk_s1_q   <= 1'b0;
            tw_clk_s2_q   <= 1'b0;
            tw_clk_prev_q <= 1'b0;
            cs_s1_q       <= 1'b1;
            cs_s2_q       <= 1'b1;
            cs_prev_q     <= 1'b1;
            dat_s1_q      <= 1'b0;
            dat_s2_q      <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            mode_q        <= 1'b0;
            addr_sh_q     <= '0;
            wdata_sh_q    <= '0;
            tx_sh_q       <= '0;
            turn_seen_q   <= 1'b0;
            load_tx_q     <= 1'b0;
            reg_addr_q    <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            abort_q       <= 1'b0;
            tw_data_q     <= 1'b0;
            oe_q          <= 1'b0;
            settle_q      <= 2'd0;
            armed_q       <= 1'b0;
        end else begin
            tw_clk_s1_q   <= in_tw_clock;
            tw_clk_s2_q   <= tw_clk_s1_q;
            tw_clk_prev_q <= tw_clk_s2_q;
            cs_s1_q       <= in_tw_cs_n;
            cs_s2_q       <= cs_s1_q;
            cs_prev_q     <= cs_s2_q;
            dat_s1_q      <= in_tw_data;
            dat_s2_q      <= dat_s1_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            mode_q        <= mode_d;
            addr_sh_q     <= addr_sh_d;
            wdata_sh_q    <= wdata_sh_d;
            tx_sh_q       <= tx_sh_d;
            turn_seen_q   <= turn_seen_d;
            load_tx_q     <= load_tx_d;
            reg_addr_q    <= reg_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            abort_q       <= abort_d;
            tw_data_q     <= tw_data_d;
            oe_q          <= oe_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
        end
    end

    assign out_tw_data     = tw_data_q;
    assign out_tw_data_oe  = oe_q;
    assign out_reg_addr    = reg_addr_q;
    assign out_reg_wr_en   = wr_en_q;
    assign out_reg_wr_data = wr_data_q;
    assign out_reg_rd_en   = rd_en_q;
    assign out_abort       = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_tw_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_tw_slave_sync
// Purpose  : Directed self-checking bench for tw_slave_sync. It acts as the
//            bus master and provides a one-cycle-latency register read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tw_slave_sync;

    logic        in_clk = 1'b0;
    logic        in_reset_n;
    logic        in_tw_clock;
    logic        in_tw_cs_n;
    logic        in_tw_data;
    logic        out_tw_data;
    logic        out_tw_data_oe;
    logic [15:0] out_reg_addr;
    logic        out_reg_wr_en;
    logic [31:0] out_reg_wr_data;
    logic        out_reg_rd_en;
    logic [31:0] in_reg_rd_data;
    logic        out_abort;

    int total = 0;
    int bad   = 0;
    int half  = 6;          // tw_clock half period in in_clk cycles

    logic [31:0] rd_value;  // word returned by the register read model

    // Monitor counters, sampled away from the active edge
    int          n_wr = 0, n_rd = 0, n_abort = 0, n_oe = 0;
    logic [15:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [31:0] last_wr_data = '0;

    tw_slave_sync #(
        .TWS_ADDRESS_BITS(16),
        .TWS_DATA_BITS   (32)
    ) dut (
        .in_clk         (in_clk),
        .in_reset_n     (in_reset_n),
        .in_tw_clock    (in_tw_clock),
        .in_tw_cs_n     (in_tw_cs_n),
        .in_tw_data     (in_tw_data),
        .out_tw_data    (out_tw_data),
        .out_tw_data_oe (out_tw_data_oe),
        .out_reg_addr   (out_reg_addr),
        .out_reg_wr_en  (out_reg_wr_en),
        .out_reg_wr_data(out_reg_wr_data),
        .out_reg_rd_en  (out_reg_rd_en),
        .in_reg_rd_data (in_reg_rd_data),
        .out_abort      (out_abort)
    );

    always #5 in_clk = ~in_clk;

    // Register file read model: data valid exactly one cycle after rd_en.
    always @(posedge in_clk) begin
        if (out_reg_rd_en) in_reg_rd_data <= rd_value;
        else               in_reg_rd_data <= 32'h5A5A5A5A;
    end

    always @(negedge in_clk) begin
        if (out_reg_wr_en) begin
            n_wr         <= n_wr + 1;
            last_wr_addr <= out_reg_addr;
            last_wr_data <= out_reg_wr_data;
        end
        if (out_reg_rd_en) begin
            n_rd         <= n_rd + 1;
            last_rd_addr <= out_reg_addr;
        end
        if (out_abort)      n_abort <= n_abort + 1;
        if (out_tw_data_oe) n_oe    <= n_oe + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half_wait();
        repeat (half) @(negedge in_clk);
    endtask

    task automatic tw_cycle(input logic d);
        in_tw_data  = d;
        half_wait();
        in_tw_clock = 1'b1;
        half_wait();
        in_tw_clock = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tw_data"}, 64'(out_tw_data), 64'd0);
        check({tag, "_oe"},      64'(out_tw_data_oe), 64'd0);
        check({tag, "_addr"},    64'(out_reg_addr), 64'd0);
        check({tag, "_wr_en"},   64'(out_reg_wr_en), 64'd0);
        check({tag, "_wr_data"}, 64'(out_reg_wr_data), 64'd0);
        check({tag, "_rd_en"},   64'(out_reg_rd_en), 64'd0);
        check({tag, "_abort"},   64'(out_abort), 64'd0);
    endtask

    // Write frame: n_cyc bus clocks of {mode,addr,data}, then extra idle
    // clocks, CS high, then gap cycles. rst_at >= 0 pulses reset before
    // that clock index.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int n_cyc,
                            input int extra, input int gap, input int rst_at);
        logic [48:0] v;
        v = {1'b1, a, d};
        in_tw_cs_n = 1'b0;
        half_wait();
        for (int k = 0; k < n_cyc; k++) begin
            if (k == rst_at) begin
                in_reset_n = 1'b0;
                repeat (2) @(negedge in_clk);
                check_reset_outputs("midrst");
                in_reset_n = 1'b1;
            end
            tw_cycle(v[48-k]);
        end
        for (int k = 0; k < extra; k++) tw_cycle(1'b0);
        in_tw_cs_n = 1'b1;
        repeat (gap) @(negedge in_clk);
    endtask

    // Read frame: 17 header clocks, one turnaround clock, 32 data clocks.
    task automatic do_read(input logic [15:0] a, input int gap, output logic [31:0] got,
                           output int oe_low_bits, output logic oe_turn, output logic oe_after);
        logic [16:0] v;
        v           = {1'b0, a};
        got         = '0;
        oe_low_bits = 0;
        in_tw_cs_n  = 1'b0;
        half_wait();
        for (int k = 0; k < 17; k++) tw_cycle(v[16-k]);
        in_tw_data = 1'b0;
        half_wait();
        oe_turn     = out_tw_data_oe;
        in_tw_clock = 1'b1;
        half_wait();
        in_tw_clock = 1'b0;
        for (int k = 0; k < 32; k++) begin
            half_wait();
            if (out_tw_data_oe !== 1'b1) oe_low_bits++;
            got         = {got[30:0], out_tw_data};
            in_tw_clock = 1'b1;
            half_wait();
            in_tw_clock = 1'b0;
        end
        half_wait();
        oe_after   = out_tw_data_oe;
        in_tw_cs_n = 1'b1;
        repeat (gap) @(negedge in_clk);
    endtask

    initial begin
        int          s_wr, s_rd, s_ab, s_oe;
        logic [31:0] got;
        int          oe_low;
        logic        oe_turn, oe_after;

        in_reset_n  = 1'b0;
        in_tw_clock = 1'b0;
        in_tw_cs_n  = 1'b1;
        in_tw_data  = 1'b0;
        rd_value    = 32'h0;
        repeat (3) @(negedge in_clk);
        check_reset_outputs("reset");
        in_reset_n = 1'b1;
        repeat (8) @(negedge in_clk);

        // Plain write
        s_wr = n_wr; s_ab = n_abort; s_oe = n_oe;
        do_write(16'h0055, 32'hEFBEADDE, 49, 0, 20, -1);
        check("wr_count",   64'(n_wr - s_wr), 64'd1);
        check("wr_addr",    64'(last_wr_addr), 64'h0055);
        check("wr_data",    64'(last_wr_data), 64'hEFBEADDE);
        check("wr_oe_cyc",  64'(n_oe - s_oe), 64'd0);
        check("wr_abort",   64'(n_abort - s_ab), 64'd0);

        // Plain read
        rd_value = 32'hAABBCCDD;
        s_wr = n_wr; s_rd = n_rd; s_ab = n_abort;
        do_read(16'h01AA, 20, got, oe_low, oe_turn, oe_after);
        check("rd_count",   64'(n_rd - s_rd), 64'd1);
        check("rd_addr",    64'(last_rd_addr), 64'h01AA);
        check("rd_data",    64'(got), 64'hAABBCCDD);
        check("rd_oe_bits", 64'(oe_low), 64'd0);
        check("rd_oe_turn", 64'(oe_turn), 64'd0);
        check("rd_oe_end",  64'(oe_after), 64'd0);
        check("rd_abort",   64'(n_abort - s_ab), 64'd0);
        check("rd_no_wr",   64'(n_wr - s_wr), 64'd0);

        // Write aborted after 10 bits, then a clean read
        s_wr = n_wr; s_ab = n_abort;
        do_write(16'h0055, 32'h11223344, 10, 0, 20, -1);
        check("ab_wr",      64'(n_wr - s_wr), 64'd0);
        check("ab_abort",   64'(n_abort - s_ab), 64'd1);
        rd_value = 32'h0BADF00D;
        s_rd = n_rd;
        do_read(16'h0123, 20, got, oe_low, oe_turn, oe_after);
        check("ab_rd_cnt",  64'(n_rd - s_rd), 64'd1);
        check("ab_rd_addr", 64'(last_rd_addr), 64'h0123);
        check("ab_rd_data", 64'(got), 64'h0BADF00D);

        // Write followed by 5 extra clocks before CS rises
        s_wr = n_wr; s_ab = n_abort;
        do_write(16'h00F0, 32'hCAFEF00D, 49, 5, 20, -1);
        check("ex_wr",      64'(n_wr - s_wr), 64'd1);
        check("ex_abort",   64'(n_abort - s_ab), 64'd0);
        check("ex_data",    64'(last_wr_data), 64'hCAFEF00D);

        // Reset pulsed during the data bits, then a clean write
        s_wr = n_wr; s_ab = n_abort;
        do_write(16'h0077, 32'hFFFFFFFF, 49, 0, 20, 22);
        check("rst_wr",     64'(n_wr - s_wr), 64'd0);
        check("rst_abort",  64'(n_abort - s_ab), 64'd0);
        do_write(16'h0001, 32'h12345678, 49, 0, 20, -1);
        check("post_wr",    64'(n_wr - s_wr), 64'd1);
        check("post_addr",  64'(last_wr_addr), 64'h0001);
        check("post_data",  64'(last_wr_data), 64'h12345678);

        // Back-to-back write then read, 1 tw clock CS gap, tw = in_clk/8
        half = 4;
        rd_value = 32'h96C3A51E;
        s_wr = n_wr; s_rd = n_rd; s_ab = n_abort;
        do_write(16'h0A0A, 32'h5555AAAA, 49, 0, 8, -1);
        do_read(16'h0B0B, 20, got, oe_low, oe_turn, oe_after);
        check("b2b_wr",     64'(n_wr - s_wr), 64'd1);
        check("b2b_waddr",  64'(last_wr_addr), 64'h0A0A);
        check("b2b_wdata",  64'(last_wr_data), 64'h5555AAAA);
        check("b2b_rd",     64'(n_rd - s_rd), 64'd1);
        check("b2b_raddr",  64'(last_rd_addr), 64'h0B0B);
        check("b2b_rdata",  64'(got), 64'h96C3A51E);
        check("b2b_abort",  64'(n_abort - s_ab), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tw_slave_sync.md
TW_SLAVE_SYNC -- requirements
Module: tw_slave_sync

Interface
REQ-001 SHALL have parameter TWS_ADDRESS_BITS, default 16, address field width in bits.
REQ-002 SHALL have parameter TWS_DATA_BITS, default 32, data field width in bits.
REQ-003 SHALL have port in_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port in_reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_tw_clock, input, 1, three-wire bus clock from the master, asynchronous to in_clk.
REQ-006 SHALL have port in_tw_cs_n, input, 1, active-low chip select, asynchronous.
REQ-007 SHALL have port in_tw_data, input, 1, bus data line as sampled from the pad.
REQ-008 SHALL have port out_tw_data, output, 1, data driven onto the bus.
REQ-009 SHALL have port out_tw_data_oe, output, 1, pad output enable; the top level builds the tristate.
REQ-010 SHALL have port out_reg_addr, output, TWS_ADDRESS_BITS, local register address.
REQ-011 SHALL have port out_reg_wr_en, output, 1, one-cycle write strobe.
REQ-012 SHALL have port out_reg_wr_data, output, TWS_DATA_BITS, write data, valid while out_reg_wr_en=1.
REQ-013 SHALL have port out_reg_rd_en, output, 1, one-cycle read request.
REQ-014 SHALL have port in_reg_rd_data, input, TWS_DATA_BITS, read data, valid exactly 1 in_clk after out_reg_rd_en.
REQ-015 SHALL have port out_abort, output, 1, one-cycle pulse on an aborted frame.

Function
REQ-016 SHALL pass in_tw_clock, in_tw_cs_n and in_tw_data through 2-flop synchronizers, then detect edges on the synchronized clock; in_clk is at least 8x the tw clock frequency.
REQ-017 Frame format SHALL be: CS low; 1 mode bit (1=write, 0=read); TWS_ADDRESS_BITS address bits; then data; all fields MSB first.
REQ-018 The master changes data after the falling edge of tw_clock; the slave SHALL sample on synchronized rising edges.
REQ-019 The FSM SHALL have states IDLE, MODE, ADDR, WDATA, TURN, RDATA and WAIT_CS.
REQ-020 IDLE->MODE SHALL occur on the synchronized CS falling edge, with the bit counter cleared.
REQ-021 MODE->ADDR SHALL occur on the first rising edge, latching the mode bit.
REQ-022 ADDR SHALL shift TWS_ADDRESS_BITS bits, then go to WDATA if mode=1 or TURN if mode=0.
REQ-023 out_reg_addr SHALL update when the last address bit is sampled.
REQ-024 On the sample of the last address bit in a read frame, out_reg_rd_en SHALL pulse for exactly 1 cycle, and in_reg_rd_data SHALL be captured into the tx shift register on the next cycle.
REQ-025 WDATA SHALL shift TWS_DATA_BITS bits; on the cycle after the last sample, out_reg_wr_en=1 for 1 cycle with the full word on out_reg_wr_data; then go to WAIT_CS.
REQ-026 TURN SHALL consume one tw_clock rising edge with OE low; at the next falling edge OE=1 and out_tw_data=MSB.
REQ-027 RDATA SHALL present the next bit at each synchronized falling edge; after TWS_DATA_BITS bits have been presented, the falling edge following the last rising edge SHALL drop OE; then go to WAIT_CS.
REQ-028 WAIT_CS SHALL ignore extra tw_clock edges (no strobes, OE low) until CS rises, then go to IDLE.
REQ-029 A CS rise in MODE, ADDR, WDATA, TURN or RDATA SHALL force IDLE, drop OE the same cycle, suppress any pending wr_en, and pulse out_abort.
REQ-030 A CS rise in WAIT_CS or IDLE SHALL NOT pulse out_abort.
REQ-031 A CS fall while the FSM is not in IDLE SHALL NOT occur (the fall is preceded by a rise that forces IDLE); back-to-back frames with a 1 tw-clock CS-high gap SHALL both be decoded.
REQ-032 out_tw_data_oe SHALL never be 1 outside TURN-end..RDATA.

Reset
REQ-033 On in_reset_n=0 at an in_clk edge, the FSM SHALL go to IDLE and counters and shift registers SHALL clear.
REQ-034 Reset values SHALL be: out_tw_data=0, out_tw_data_oe=0, out_reg_addr=0, out_reg_wr_en=0, out_reg_wr_data=0, out_reg_rd_en=0, out_abort=0; synchronizer flops reset to CS=1 and clock=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame without wr_en or abort; after release, the remainder of that frame SHALL be ignored until CS rises.

Verification
REQ-036 Write frame, mode=1, addr 0x0055, data 0xEFBEADDE -> a single wr_en pulse with addr=0x0055, wr_data=0xEFBEADDE; OE stays 0 throughout.
REQ-037 Read frame, addr 0x01AA, in_reg_rd_data=0xAABBCCDD -> a single rd_en pulse with addr=0x01AA; the master samples 0xAABBCCDD MSB first; OE drops after bit 0.
REQ-038 CS raised after 10 bits of a write -> no wr_en, a single abort pulse, FSM in IDLE; the next full read frame returns correct data.
REQ-039 Write frame followed by 5 extra tw clocks before the CS rise -> exactly one wr_en and no abort.
REQ-040 Reset pulsed during the WDATA bits -> no wr_en and no abort; all outputs at reset values; a later write to 0x0001 with data 0x12345678 is decoded.
REQ-041 Back-to-back write then read, with a 1-clock CS gap, at tw_clock = in_clk/8 -> both frames decoded correctly.
